// File: rtl/sound_noise_ctrl.sv
// Noise channel register front-end and frame sequencer.
// Holds NR41..NR44, generates length/envelope ticks and the start pulse.
module sound_noise_ctrl #(
  parameter int DIV_WIDTH    = 13,
  parameter int START_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_en,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] frame_step,
  output logic       tick_length,
  output logic       tick_env,
  output logic [5:0] length,
  output logic [3:0] initial_volume,
  output logic       envelope_increasing,
  output logic [2:0] num_envelope_sweeps,
  output logic [3:0] shift_clock_freq,
  output logic       counter_width,
  output logic [2:0] freq_dividing_ratio,
  output logic       single,
  output logic       start
);

  localparam logic [3:0] START_LOAD = 4'(START_CYCLES);

  logic [DIV_WIDTH-1:0] presc;
  logic [2:0]           step;
  logic [3:0]           cnt;
  logic [5:0]           nr41;
  logic [7:0]           nr42;
  logic [7:0]           nr43;
  logic                 nr44_single;

  logic wr_en;
  logic wrap;
  logic dac_on;
  logic trig;
  logic dac_kill;

  assign wr_en    = wr & master_en;
  assign wrap     = &presc;
  assign dac_on   = |nr42[7:3];
  assign trig     = wr_en && addr == 2'd3 && din[7] && dac_on;
  assign dac_kill = wr_en && addr == 2'd1 && din[7:3] == 5'd0;

  always_ff @(posedge clk) begin
    if (rst || !master_en) begin
      presc       <= '0;
      step        <= 3'd0;
      tick_length <= 1'b0;
      tick_env    <= 1'b0;
    end else begin
      presc       <= presc + 1'b1;
      tick_length <= wrap & ~step[0];
      tick_env    <= wrap & (step == 3'd7);
      if (wrap)
        step <= step + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !master_en) begin
      nr41        <= 6'd0;
      nr42        <= 8'd0;
      nr43        <= 8'd0;
      nr44_single <= 1'b0;
    end else if (wr_en) begin
      unique case (1'b1)
        addr == 2'd0: nr41        <= din[5:0];
        addr == 2'd1: nr42        <= din;
        addr == 2'd2: nr43        <= din;
        addr == 2'd3: nr44_single <= din[6];
      endcase
    end
  end

  // Trigger checks the already-registered NR42 DAC bits.
  always_ff @(posedge clk) begin
    if (rst || !master_en)
      cnt <= 4'd0;
    else if (trig)
      cnt <= START_LOAD;
    else if (dac_kill)
      cnt <= 4'd0;
    else if (cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  always_comb begin
    dout = 8'hFF;
    unique case (1'b1)
      addr == 2'd0: dout = 8'hFF;
      addr == 2'd1: dout = nr42;
      addr == 2'd2: dout = nr43;
      addr == 2'd3: dout = {1'b1, nr44_single, 6'h3F};
    endcase
  end

  assign frame_step          = step;
  assign start               = cnt != 4'd0;
  assign length              = nr41;
  assign initial_volume      = nr42[7:4];
  assign envelope_increasing = nr42[3];
  assign num_envelope_sweeps = nr42[2:0];
  assign shift_clock_freq    = nr43[7:4];
  assign counter_width       = nr43[3];
  assign freq_dividing_ratio = nr43[2:0];
  assign single              = nr44_single;

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Scoreboard bench for sound_noise_ctrl (DIV_WIDTH=3, START_CYCLES=4).
// Stimulus queues expected values per cycle; a monitor pops and compares.
module tb_sound_noise_ctrl;

  logic       clk;
  logic       rst;
  logic       master_en;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [2:0] frame_step;
  logic       tick_length;
  logic       tick_env;
  logic [5:0] length;
  logic [3:0] initial_volume;
  logic       envelope_increasing;
  logic [2:0] num_envelope_sweeps;
  logic [3:0] shift_clock_freq;
  logic       counter_width;
  logic [2:0] freq_dividing_ratio;
  logic       single;
  logic       start;

  sound_noise_ctrl #(.DIV_WIDTH(3), .START_CYCLES(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .master_en           (master_en),
    .wr                  (wr),
    .addr                (addr),
    .din                 (din),
    .dout                (dout),
    .frame_step          (frame_step),
    .tick_length         (tick_length),
    .tick_env            (tick_env),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .shift_clock_freq    (shift_clock_freq),
    .counter_width       (counter_width),
    .freq_dividing_ratio (freq_dividing_ratio),
    .single              (single),
    .start               (start)
  );

  localparam int S_TL  = 0;
  localparam int S_TE  = 1;
  localparam int S_ST  = 2;
  localparam int S_FS  = 3;
  localparam int S_CFG = 4;
  localparam int S_DO  = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(int c, int s, logic [31:0] v, string n);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    e.nm  = n;
    q.push_back(e);
  endfunction

  function automatic logic [31:0] mk_cfg(logic [5:0] l, logic [7:0] a,
                                         logic [7:0] b, logic s);
    return {9'd0, l, a, b, s};
  endfunction

  function automatic logic [31:0] act(int s);
    case (s)
      S_TL:  return {31'd0, tick_length};
      S_TE:  return {31'd0, tick_env};
      S_ST:  return {31'd0, start};
      S_FS:  return {29'd0, frame_step};
      S_CFG: return {9'd0, length, initial_volume, envelope_increasing,
                     num_envelope_sweeps, shift_clock_freq, counter_width,
                     freq_dividing_ratio, single};
      S_DO:  return {24'd0, dout};
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (act(q[i].sel) !== q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                   q[i].nm, cyc, act(q[i].sel), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input logic [1:0] a, input logic [7:0] d, input logic w);
    addr = a;
    din  = d;
    wr   = w;
  endtask

  initial begin
    int c0;
    int t;
    rst       = 1'b1;
    master_en = 1'b1;
    put(2'd0, 8'h00, 1'b0);
    step();

    // reset with random writes
    for (int i = 0; i < 20; i++) begin
      put(2'd0, 8'($urandom), 1'($urandom));
      push(cyc + 1, S_TL, 0, "rst_tick_length");
      push(cyc + 1, S_TE, 0, "rst_tick_env");
      push(cyc + 1, S_ST, 0, "rst_start");
      push(cyc + 1, S_FS, 0, "rst_frame_step");
      push(cyc + 1, S_CFG, 0, "rst_cfg");
      push(cyc + 1, S_DO, 32'hFF, "rst_dout_nr41");
      step();
    end

    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct_start actual=%0b", start);
    end
    checks++;
    if (tick_length !== 1'b0 || tick_env !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct_ticks tl=%0b te=%0b", tick_length, tick_env);
    end
    checks++;
    if (frame_step !== 3'd0) begin
      failures++;
      $display("FAIL rst_direct_frame_step actual=%0d", frame_step);
    end
    checks++;
    if (dout !== 8'hFF) begin
      failures++;
      $display("FAIL rst_direct_dout actual=%0h", dout);
    end
    checks++;
    if (act(S_CFG) !== 32'd0) begin
      failures++;
      $display("FAIL rst_direct_cfg actual=%0h", act(S_CFG));
    end

    // frame sequencer over 72 cycles
    rst = 1'b0;
    put(2'd0, 8'h00, 1'b0);
    c0 = cyc;
    for (int k = 1; k <= 72; k++) begin
      push(c0 + k, S_TL, (k >= 8 && (k - 8) % 16 == 0) ? 1 : 0, "tick_length");
      push(c0 + k, S_TE, (k == 64) ? 1 : 0, "tick_env");
      push(c0 + k, S_FS, (k / 8) % 8, "frame_step");
    end
    repeat (72) step();

    // config writes and a single trigger
    put(2'd1, 8'hF3, 1'b1); step();
    put(2'd2, 8'h5A, 1'b1); step();
    t = cyc;
    put(2'd3, 8'hC0, 1'b1);
    push(t + 1, S_CFG, mk_cfg(6'd0, 8'hF3, 8'h5A, 1'b1), "cfg_after_writes");
    for (int k = 1; k <= 6; k++)
      push(t + k, S_ST, (k <= 4) ? 1 : 0, "start_single");
    push(t + 2, S_DO, 32'hFF, "dout_nr44");
    push(t + 3, S_DO, 32'hF3, "dout_nr42");
    push(t + 4, S_DO, 32'h5A, "dout_nr43");
    push(t + 5, S_DO, 32'hFF, "dout_nr41");
    step(); put(2'd3, 8'h00, 1'b0);
    step(); put(2'd1, 8'h00, 1'b0);
    step(); put(2'd2, 8'h00, 1'b0);
    step(); put(2'd0, 8'h00, 1'b0);
    repeat (4) step();

    // retrigger two cycles after the first trigger
    t = cyc;
    for (int k = 1; k <= 8; k++)
      push(t + k, S_ST, (k <= 6) ? 1 : 0, "start_retrigger");
    put(2'd3, 8'hC0, 1'b1); step();
    put(2'd3, 8'h00, 1'b0); step();
    put(2'd3, 8'hC0, 1'b1); step();
    put(2'd0, 8'h00, 1'b0);
    repeat (8) step();

    // DAC off: trigger ignored
    t = cyc;
    for (int k = 1; k <= 6; k++)
      push(t + k, S_ST, 0, "start_dac_off");
    push(t + 3, S_CFG, mk_cfg(6'h25, 8'h07, 8'h5A, 1'b0), "cfg_dac_off");
    push(t + 4, S_DO, 32'hFF, "dout_nr41_b");
    push(t + 5, S_DO, 32'hBF, "dout_nr44_single0");
    put(2'd1, 8'h07, 1'b1); step();
    put(2'd0, 8'hE5, 1'b1); step();
    put(2'd3, 8'h80, 1'b1); step();
    put(2'd0, 8'h00, 1'b0); step();
    put(2'd3, 8'h00, 1'b0); step();
    step(); step();

    // DAC cleared while start is high
    t = cyc;
    push(t + 1, S_ST, 0, "start_kill_pre");
    push(t + 2, S_ST, 1, "start_kill_on");
    push(t + 3, S_ST, 0, "start_kill_off");
    push(t + 4, S_ST, 0, "start_kill_off2");
    push(t + 5, S_ST, 0, "start_kill_off3");
    put(2'd1, 8'hF0, 1'b1); step();
    put(2'd3, 8'hC0, 1'b1); step();
    put(2'd1, 8'h00, 1'b1); step();
    put(2'd0, 8'h00, 1'b0);
    repeat (4) step();

    // master_en drop mid-pulse, then writes while powered off
    t = cyc;
    push(t + 2, S_ST, 1, "start_pre_off");
    push(t + 3, S_ST, 1, "start_pre_off2");
    push(t + 3, S_CFG, mk_cfg(6'h25, 8'hF3, 8'h5A, 1'b1), "cfg_pre_off");
    for (int k = 4; k <= 9; k++) begin
      push(t + k, S_ST, 0, "start_off");
      push(t + k, S_CFG, 0, "cfg_off");
      push(t + k, S_TL, 0, "tick_length_off");
      push(t + k, S_TE, 0, "tick_env_off");
      push(t + k, S_FS, 0, "frame_step_off");
    end
    push(t + 8, S_DO, 0, "dout_nr42_off");
    put(2'd1, 8'hF3, 1'b1); step();
    put(2'd3, 8'hC0, 1'b1); step();
    put(2'd0, 8'h00, 1'b0); step();
    master_en = 1'b0; step();
    put(2'd1, 8'hFF, 1'b1); step();
    put(2'd2, 8'hFF, 1'b1); step();
    put(2'd3, 8'hC0, 1'b1); step();
    put(2'd1, 8'h00, 1'b0); step();
    step();

    // power back on: prescaler restarts from zero
    master_en = 1'b1;
    put(2'd0, 8'h00, 1'b0);
    t = cyc;
    for (int k = 1; k <= 9; k++) begin
      push(t + k, S_TL, (k == 8) ? 1 : 0, "tick_length_restart");
      push(t + k, S_FS, (k >= 8) ? 1 : 0, "frame_step_restart");
    end
    repeat (12) step();

    foreach (q[i]) begin
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d actual=unchecked required=%0h",
               q[i].nm, q[i].cyc, q[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
